// File: rtl/hex_overlay_pkg.sv
// Shared constants and state encoding for the hex digit overlay.
package hex_overlay_pkg;

  localparam int GLYPH_W = 5;
  localparam int GLYPH_H = 5;
  localparam int CELL_W  = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/hex_overlay_if.sv
// Sync-generator, value-load and glyph-ROM signals between the overlay and its parent.
interface hex_overlay_if #(
  parameter int NDIGITS = 4
);
  logic [9:0]           hpos;
  logic [9:0]           vpos;
  logic                 display_on;
  logic [4*NDIGITS-1:0] value;
  logic                 value_load;
  logic [3:0]           rom_digit;
  logic [2:0]           rom_yofs;
  logic [4:0]           rom_bits;
  logic                 pixel;
  logic                 pixel_de;

  modport master (
    output hpos, vpos, display_on, value, value_load, rom_bits,
    input  rom_digit, rom_yofs, pixel, pixel_de
  );

  modport slave (
    input  hpos, vpos, display_on, value, value_load, rom_bits,
    output rom_digit, rom_yofs, pixel, pixel_de
  );
endinterface

// File: rtl/hex_overlay.sv
// Draws an NDIGITS-wide hex value as scaled 5x5 glyphs at (X0, Y0); two-clock pixel latency.
//   state | meaning
//   IDLE  | outside the overlay span on this line
//   RUN   | walking sub-pixel / glyph column / digit counters across the span
module hex_overlay
  import hex_overlay_pkg::*;
#(
  parameter int NDIGITS    = 4,
  parameter int X0         = 16,
  parameter int Y0         = 16,
  parameter int SCALE_LOG2 = 1
) (
  input logic         clk,
  input logic         reset_n,
  hex_overlay_if.slave bus
);

  localparam int VW    = 4 * NDIGITS;
  localparam int SUB_W = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
  localparam int DIG_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'((1 << SCALE_LOG2) - 1);
  localparam logic [2:0]       COL_MAX = 3'(CELL_W - 1);
  localparam logic [DIG_W-1:0] DIG_MAX = DIG_W'(NDIGITS - 1);

  logic [VW-1:0] shown_q, pending_q;
  logic          pend_valid_q;
  logic          frame_start;

  assign frame_start = (bus.hpos == 10'd0) && (bus.vpos == 10'd0);

  // A load coinciding with frame start bypasses the pending register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shown_q      <= '0;
      pending_q    <= '0;
      pend_valid_q <= 1'b0;
    end else if (frame_start && bus.value_load) begin
      shown_q      <= bus.value;
      pending_q    <= bus.value;
      pend_valid_q <= 1'b0;
    end else if (frame_start && pend_valid_q) begin
      shown_q      <= pending_q;
      pend_valid_q <= 1'b0;
    end else if (bus.value_load) begin
      pending_q    <= bus.value;
      pend_valid_q <= 1'b1;
    end
  end

  logic [9:0] rel_y, yrow_full;
  logic       band_act;

  assign rel_y     = bus.vpos - 10'(Y0);
  assign yrow_full = rel_y >> SCALE_LOG2;
  assign band_act  = (bus.vpos >= 10'(Y0)) && (yrow_full < 10'(GLYPH_H));

  state_e           state_q, state_d;
  logic [SUB_W-1:0] sub_q, sub_d, cur_sub;
  logic [2:0]       col_q, col_d, cur_col;
  logic [DIG_W-1:0] dig_q, dig_d, cur_dig, dig_rev;
  logic             restart, cur_act, last_cell;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sub_q   <= '0;
      col_q   <= '0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      col_q   <= col_d;
      dig_q   <= dig_d;
    end
  end

  // Position of the current hpos: the restart cycle already counts as cell (0,0,0)
  // so the first glyph pixel keeps the same two-clock latency as the rest.
  always_comb begin
    restart   = (bus.hpos == 10'(X0)) && band_act;
    cur_act   = restart || ((state_q == ST_RUN) && band_act);
    cur_sub   = restart ? '0 : sub_q;
    cur_col   = restart ? '0 : col_q;
    cur_dig   = restart ? '0 : dig_q;
    last_cell = (cur_sub == SUB_MAX) && (cur_col == COL_MAX) && (cur_dig == DIG_MAX);
    dig_rev   = DIG_MAX - cur_dig;
  end

  always_comb begin
    state_d = ST_IDLE;
    sub_d   = sub_q;
    col_d   = col_q;
    dig_d   = dig_q;
    if (cur_act) begin
      state_d = last_cell ? ST_IDLE : ST_RUN;
      if (cur_sub == SUB_MAX) begin
        sub_d = '0;
        if (cur_col == COL_MAX) begin
          col_d = '0;
          dig_d = (cur_dig == DIG_MAX) ? '0 : cur_dig + DIG_W'(1);
        end else begin
          col_d = cur_col + 3'd1;
        end
      end else begin
        sub_d = cur_sub + SUB_W'(1);
      end
    end
  end

  logic [3:0] rom_digit_q;
  logic [2:0] rom_yofs_q;
  logic       act1_q, de1_q;
  logic [2:0] col1_q;
  logic       pixel_q, pixel_de_q;
  logic [4:0] row_shift;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_digit_q <= '0;
      rom_yofs_q  <= '0;
      act1_q      <= 1'b0;
      col1_q      <= '0;
      de1_q       <= 1'b0;
    end else begin
      rom_digit_q <= shown_q[{dig_rev, 2'b00} +: 4];
      rom_yofs_q  <= yrow_full[2:0];
      act1_q      <= cur_act;
      col1_q      <= cur_col;
      de1_q       <= bus.display_on;
    end
  end

  assign row_shift = bus.rom_bits >> (3'(GLYPH_W - 1) - col1_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_q    <= 1'b0;
      pixel_de_q <= 1'b0;
    end else begin
      pixel_q    <= act1_q && (col1_q < 3'(GLYPH_W)) && row_shift[0];
      pixel_de_q <= de1_q;
    end
  end

  assign bus.rom_digit = rom_digit_q;
  assign bus.rom_yofs  = rom_yofs_q;
  assign bus.pixel     = pixel_q;
  assign bus.pixel_de  = pixel_de_q;

endmodule
